tx_flit_arbiter: RTL and testbench

Sequential transmit scheduler between the four NoC transmit queues (ack, waiting-ack retransmit, forwarded, cpu-to-noc) and the interdevice controller's tx port. It grants exactly one queue per cycle, keeps multi-flit packets contiguous on the link, and gives ack flits priority between packets. It round-robins the three packet sources and releases a stalled packet lock after a timeout. A one-deep registered output stage decouples the grant logic from the interdevice tx handshake.

---
 rtl/tx_flit_arbiter_pkg.sv | 34 +++
 rtl/tx_flit_arbiter_rr_pick3.sv | 33 +++
 rtl/tx_flit_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tx_flit_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_flit_arbiter_pkg.sv
// Shared types for the NoC transmit arbiter: flit header layout and source ids.
package tx_flit_arbiter_pkg;

  typedef enum logic [1:0] {
    HEAD   = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    SINGLE = 2'd3
  } flit_type_t;

  typedef enum logic [1:0] {
    SRC_ACK  = 2'd0,
    SRC_RETX = 2'd1,
    SRC_FWD  = 2'd2,
    SRC_CPU  = 2'd3
  } tx_src_t;

  localparam int FLIT_PAYLOAD_W = 30;

  typedef struct packed {
    flit_type_t                flit_type;
    logic [FLIT_PAYLOAD_W-1:0] payload;
  } flit_t;

  function automatic flit_type_t flit_type_of(flit_t f);
    return f.flit_type;
  endfunction

  // Round-robin successor among the packet sources 1..3.
  function automatic tx_src_t rr_next(tx_src_t s);
    return (s == SRC_CPU) ? SRC_RETX : tx_src_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/tx_flit_arbiter_rr_pick3.sv
// Combinational round-robin picker over the three packet sources (1..3).
module rr_pick3
  import tx_flit_arbiter_pkg::*;
(
  input  logic [3:1] vld_i,
  input  tx_src_t    rr_ptr_i,
  output tx_src_t    grant_o,
  output logic       grant_any_o
);

  tx_src_t ord [3];

  always_comb begin
    case (rr_ptr_i)
      SRC_FWD: ord = '{SRC_FWD, SRC_CPU, SRC_RETX};
      SRC_CPU: ord = '{SRC_CPU, SRC_RETX, SRC_FWD};
      default: ord = '{SRC_RETX, SRC_FWD, SRC_CPU};
    endcase
  end

  // Scan from lowest priority up so the first valid in order wins.
  always_comb begin
    grant_o     = SRC_RETX;
    grant_any_o = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (vld_i[ord[k]]) begin
        grant_o     = ord[k];
        grant_any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_flit_arbiter.sv
// Transmit scheduler: ack priority between packets, packet lock with timeout,
// round-robin over retx/fwd/cpu, one-deep registered output stage.
module tx_flit_arbiter
  import tx_flit_arbiter_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       nocclk,
  input  logic       rst,
  input  flit_t      ack_flit,
  input  logic       ack_flit_valid,
  output logic       ack_flit_ready,
  input  flit_t      retx_flit,
  input  logic       retx_flit_valid,
  output logic       retx_flit_ready,
  input  flit_t      fwd_flit,
  input  logic       fwd_flit_valid,
  output logic       fwd_flit_ready,
  input  flit_t      cpu_flit,
  input  logic       cpu_flit_valid,
  output logic       cpu_flit_ready,
  output flit_t      flit_out,
  output logic       flit_out_valid,
  input  logic       flit_out_ready,
  output logic [1:0] locked_src,
  output logic       busy,
  output logic       lock_timeout,
  output logic       protocol_error
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  tx_src_t       lsrc_q, lsrc_d;
  tx_src_t       rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  flit_t         out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          perr_q, perr_d;
  logic          tmo_q, tmo_d;

  flit_t [3:0]   in_flit;
  logic  [3:0]   in_vld, in_rdy;
  tx_src_t       rr_gnt, sel;
  logic          rr_any, sel_vld, accept_ok, accept, fwd;
  flit_t         acc_flit;
  flit_type_t    acc_type;

  assign in_flit = {cpu_flit, fwd_flit, retx_flit, ack_flit};
  assign in_vld  = {cpu_flit_valid, fwd_flit_valid, retx_flit_valid, ack_flit_valid};

  rr_pick3 u_pick (
    .vld_i       (in_vld[3:1]),
    .rr_ptr_i    (rr_q),
    .grant_o     (rr_gnt),
    .grant_any_o (rr_any)
  );

  assign accept_ok = (!out_vld_q || flit_out_ready) && !rst;

  // A held lock shadows everything, including ack.
  always_comb begin
    sel     = rr_gnt;
    sel_vld = rr_any;
    if (state_q == ST_LOCKED) begin
      sel     = lsrc_q;
      sel_vld = in_vld[lsrc_q];
    end else if (ack_flit_valid) begin
      sel     = SRC_ACK;
      sel_vld = 1'b1;
    end
  end

  assign accept   = sel_vld && accept_ok;
  assign in_rdy   = accept ? 4'(4'b1 << sel) : 4'b0;
  assign {cpu_flit_ready, fwd_flit_ready, retx_flit_ready, ack_flit_ready} = in_rdy;
  assign acc_flit = in_flit[sel];
  assign acc_type = flit_type_of(acc_flit);

  always_comb begin
    state_d = state_q;
    lsrc_d  = lsrc_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    perr_d  = 1'b0;
    tmo_d   = 1'b0;
    fwd     = 1'b0;
    if (accept && sel != SRC_ACK) rr_d = rr_next(sel);
    if (state_q == ST_IDLE) begin
      if (accept) begin
        unique case (acc_type)
          SINGLE: fwd = 1'b1;
          HEAD: begin
            fwd = 1'b1;
            if (sel == SRC_ACK) perr_d = 1'b1;
            else begin
              state_d = ST_LOCKED;
              lsrc_d  = sel;
              cnt_d   = '0;
            end
          end
          default: perr_d = 1'b1;
        endcase
      end
    end else if (accept) begin
      fwd   = 1'b1;
      cnt_d = '0;
      if (acc_type != BODY) state_d = ST_IDLE;
      if (acc_type == HEAD || acc_type == SINGLE) perr_d = 1'b1;
    end else if (!in_vld[lsrc_q]) begin
      // Only an absent source counts; output backpressure never times out.
      if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        tmo_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (fwd) begin
      out_d     = acc_flit;
      out_vld_d = 1'b1;
    end else if (flit_out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lsrc_q    <= SRC_ACK;
      rr_q      <= SRC_RETX;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      perr_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lsrc_q    <= lsrc_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      perr_q    <= perr_d;
      tmo_q     <= tmo_d;
    end
  end

  assign flit_out       = out_q;
  assign flit_out_valid = out_vld_q;
  assign busy           = (state_q == ST_LOCKED);
  assign locked_src     = lsrc_q;
  assign lock_timeout   = tmo_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_tx_flit_arbiter.sv
// Scoreboard bench for tx_flit_arbiter: transaction-level reference model plus output monitor.
module tb_tx_flit_arbiter;
  import tx_flit_arbiter_pkg::*;

  localparam int LT = 64;

  logic       nocclk = 1'b0;
  logic       rst = 1'b1;
  flit_t      fl [4];
  logic [3:0] vi, ri;
  flit_t      flit_out;
  logic       flit_out_valid, flit_out_ready;
  logic [1:0] locked_src;
  logic       busy, lock_timeout, protocol_error;

  always #5 nocclk = ~nocclk;

  tx_flit_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .nocclk(nocclk), .rst(rst),
    .ack_flit(fl[0]),  .ack_flit_valid(vi[0]),  .ack_flit_ready(ri[0]),
    .retx_flit(fl[1]), .retx_flit_valid(vi[1]), .retx_flit_ready(ri[1]),
    .fwd_flit(fl[2]),  .fwd_flit_valid(vi[2]),  .fwd_flit_ready(ri[2]),
    .cpu_flit(fl[3]),  .cpu_flit_valid(vi[3]),  .cpu_flit_ready(ri[3]),
    .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
    .locked_src(locked_src), .busy(busy), .lock_timeout(lock_timeout),
    .protocol_error(protocol_error)
  );

  int     checks = 0, errs = 0;
  flit_t  srcq [4][$];
  int     en [4];
  bit     rnd_ready = 0;
  flit_t  expq [$];
  int     seq = 0;

  // reference model state
  bit     m_lock, m_ovld, e_perr, e_tmo, aok, fwd, np, nt;
  int     m_src, m_rr, m_cnt, g, s_i;
  int     tmo_seen = 0, perr_seen = 0;
  flit_t  f;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: decides the legal grant from queue/packet rules and
  // predicts output flits and pulses.
  always @(negedge nocclk) begin
    if (rst) begin
      chk("rst_ready", {60'd0, ri}, 64'd0);
      chk("rst_out_valid", {63'd0, flit_out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      m_lock = 0; m_src = 0; m_rr = 1; m_cnt = 0; m_ovld = 0; e_perr = 0; e_tmo = 0;
      expq.delete();
    end else begin
      chk("busy", {63'd0, busy}, {63'd0, m_lock});
      if (m_lock) chk("locked_src", {62'd0, locked_src}, 64'(m_src));
      chk("out_valid", {63'd0, flit_out_valid}, {63'd0, m_ovld});
      chk("protocol_error", {63'd0, protocol_error}, {63'd0, e_perr});
      chk("lock_timeout", {63'd0, lock_timeout}, {63'd0, e_tmo});
      if (lock_timeout) tmo_seen++;
      if (protocol_error) perr_seen++;
      aok = !m_ovld || flit_out_ready;
      g = -1;
      if (aok) begin
        if (m_lock) begin
          if (vi[m_src]) g = m_src;
        end else if (vi[0]) g = 0;
        else begin
          for (int k = 0; k < 3; k++) begin
            s_i = (m_rr - 1 + k) % 3 + 1;
            if (g < 0 && vi[s_i]) g = s_i;
          end
        end
      end
      chk("grant", {60'd0, vi & ri}, (g < 0) ? 64'd0 : (64'd1 << g));
      np = 0; nt = 0; fwd = 0;
      if (g >= 0) begin
        f = fl[g];
        if (!m_lock) begin
          if (f.flit_type == SINGLE) fwd = 1;
          else if (f.flit_type == HEAD) begin
            fwd = 1;
            if (g == 0) np = 1;
            else begin m_lock = 1; m_src = g; m_cnt = 0; end
          end else np = 1;
        end else begin
          fwd = 1; m_cnt = 0;
          if (f.flit_type == TAIL) m_lock = 0;
          else if (f.flit_type != BODY) begin np = 1; m_lock = 0; end
        end
        if (g != 0) m_rr = g % 3 + 1;
      end else if (m_lock && !vi[m_src]) begin
        m_cnt++;
        if (m_cnt == LT) begin m_lock = 0; m_cnt = 0; nt = 1; end
      end
      if (fwd) begin expq.push_back(f); m_ovld = 1; end
      else if (flit_out_ready) m_ovld = 0;
      e_perr = np; e_tmo = nt;
    end
  end

  // Output monitor: every presented flit must match the scoreboard head.
  always @(negedge nocclk) begin
    if (!rst && flit_out_valid) begin
      if (expq.size() == 0) begin
        checks++; errs++;
        $display("FAIL out_unexpected: got %0h expected none at %0t", flit_out, $time);
      end else begin
        chk("flit_out", 64'(flit_out), 64'(expq[0]));
        if (flit_out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic push(int s, flit_type_t t);
    flit_t x;
    x.flit_type = t;
    x.payload   = {s[1:0], seq[27:0]};
    seq++;
    srcq[s].push_back(x);
  endtask

  task automatic push_pkt(int s);
    int r = $urandom_range(9);
    if (s == 0 || r < 3) push(s, SINGLE);
    else if (r == 9) push(s, flit_type_t'($urandom_range(3)));
    else begin
      push(s, HEAD);
      repeat ($urandom_range(3)) push(s, BODY);
      push(s, TAIL);
    end
  endtask

  task automatic cycle();
    logic [3:0] hs;
    @(negedge nocclk);
    hs = vi & ri;
    @(posedge nocclk);
    #1;
    for (int s = 0; s < 4; s++) begin
      if (hs[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
      if (srcq[s].size() > 0 && $urandom_range(99) < en[s]) begin
        vi[s] = 1'b1; fl[s] = srcq[s][0];
      end else begin
        vi[s] = 1'b0; fl[s] = '0;
      end
    end
    if (rnd_ready) flit_out_ready = ($urandom_range(99) < 70);
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic drain(string name);
    int b = 0;
    rnd_ready = 0; flit_out_ready = 1'b1;
    for (int s = 0; s < 4; s++) en[s] = 100;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() > 0
            || expq.size() > 0 || flit_out_valid) && b < 3000) begin
      cycle(); b++;
    end
    checks++;
    if (b >= 3000) begin
      errs++;
      $display("FAIL %s_drain: got %0d flits pending expected 0", name, expq.size());
    end
    run(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
  endtask

  initial begin
    int p0, t0, b;
    vi = '0; flit_out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin fl[s] = '0; en[s] = 100; end
    repeat (2) @(posedge nocclk);
    #1;
    chk("rst_flit_out", 64'(flit_out), 64'd0);
    chk("rst_locked_src", {62'd0, locked_src}, 64'd0);
    chk("rst_pulses", {62'd0, lock_timeout, protocol_error}, 64'd0);
    rst = 1'b0;

    // ack SINGLE beats cpu HEAD in IDLE; cpu then locks
    push(0, SINGLE); push(3, HEAD);
    cycle();
    cycle();
    chk("t1_ack_first", {62'd0, flit_out.payload[29:28]}, 64'd0);
    cycle();
    chk("t1_cpu_head", {62'd0, flit_out.payload[29:28]}, 64'd3);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_locked_src", {62'd0, locked_src}, 64'd3);
    push(3, TAIL);
    drain("t1");

    // fwd packet holds the link while ack waits
    en[0] = 0;
    push(2, HEAD); push(2, BODY); push(2, BODY); push(2, TAIL);
    run(2);
    push(0, SINGLE); en[0] = 100;
    drain("t2");

    // round robin from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin push(1, SINGLE); push(2, SINGLE); push(3, SINGLE); end
    run(2);
    chk("t3_first_rr", {62'd0, flit_out.payload[29:28]}, 64'd1);
    drain("t3");

    // lock timeout, then a late BODY is a protocol error
    push(3, HEAD);
    run(3);
    t0 = tmo_seen;
    run(LT + 5);
    chk("t4_timeout_once", 64'(tmo_seen - t0), 64'd1);
    chk("t4_unlocked", {63'd0, busy}, 64'd0);
    p0 = perr_seen;
    push(3, BODY);
    run(4);
    chk("t4_late_body_err", 64'(perr_seen - p0), 64'd1);
    drain("t4");

    // output backpressure mid-packet
    t0 = tmo_seen;
    push(2, HEAD);
    repeat (6) push(2, BODY);
    push(2, TAIL);
    run(3);
    flit_out_ready = 1'b0;
    run(10);
    chk("t5_no_timeout", 64'(tmo_seen - t0), 64'd0);
    flit_out_ready = 1'b1;
    drain("t5");

    // randomized traffic
    rnd_ready = 1;
    for (int s = 0; s < 4; s++) en[s] = 40 + $urandom_range(60);
    for (int i = 0; i < 1500; i++) begin
      for (int s = 0; s < 4; s++)
        if (srcq[s].size() < 3 && $urandom_range(3) == 0) push_pkt(s);
      cycle();
    end
    drain("t6");

    // reset while locked with a held output flit
    push(3, HEAD); push(3, BODY); push(3, BODY); push(3, BODY);
    run(3);
    flit_out_ready = 1'b0;
    run(1);
    chk("t7_pre_busy", {63'd0, busy}, 64'd1);
    chk("t7_pre_valid", {63'd0, flit_out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", {63'd0, flit_out_valid}, 64'd0);
    chk("t7_rst_busy", {63'd0, busy}, 64'd0);
    for (int s = 0; s < 4; s++) srcq[s].delete();
    flit_out_ready = 1'b1;
    push(0, SINGLE); push(1, SINGLE);
    run(2);
    rst = 1'b0;
    b = 0;
    while (!flit_out_valid && b < 10) begin cycle(); b++; end
    chk("t7_first_after_rst", {62'd0, flit_out.payload[29:28]}, 64'd0);
    drain("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
